// File: rtl/condicionador_botoes_pkg.sv
// rtl/condicionador_botoes_pkg.sv - shared types and helpers for the pushbutton conditioner
package botoes_pkg;

    localparam int NUM_CORES = 4;

    typedef enum logic [1:0] {
        VERMELHO = 2'd0,
        AZUL     = 2'd1,
        AMARELO  = 2'd2,
        VERDE    = 2'd3
    } cor_t;

    typedef enum logic {
        OCIOSO        = 1'b0,
        ESPERA_SOLTAR = 1'b1
    } estado_botoes_t;

    function automatic logic eh_one_hot(input logic [NUM_CORES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            n = n + int'(v[i]);
        end
        return (n == 1);
    endfunction

    // Only meaningful for a one-hot vector; callers check that first.
    function automatic cor_t codifica_cor(input logic [NUM_CORES-1:0] v);
        cor_t c;
        c = VERMELHO;
        if (v[1]) c = AZUL;
        if (v[2]) c = AMARELO;
        if (v[3]) c = VERDE;
        return c;
    endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// rtl/condicionador_botoes_if.sv - raw key pins and conditioned pulses toward the game FSM
interface condicionador_botoes_if;
    import botoes_pkg::*;

    logic [NUM_CORES-1:0] btn_cor_raw;
    logic                 btn_iniciar_raw;
    logic                 btn_ultima_raw;

    logic                 Bot_Vermelho;
    logic                 Bot_Azul;
    logic                 Bot_Amarelo;
    logic                 Bot_Verde;
    logic [1:0]           cor_codigo;
    logic                 Iniciar_Jogo;
    logic                 Bot_Ultima_Sequencia;
    logic                 erro_multiplo;

    modport master (
        output btn_cor_raw, btn_iniciar_raw, btn_ultima_raw,
        input  Bot_Vermelho, Bot_Azul, Bot_Amarelo, Bot_Verde, cor_codigo,
               Iniciar_Jogo, Bot_Ultima_Sequencia, erro_multiplo
    );

    modport slave (
        input  btn_cor_raw, btn_iniciar_raw, btn_ultima_raw,
        output Bot_Vermelho, Bot_Azul, Bot_Amarelo, Bot_Verde, cor_codigo,
               Iniciar_Jogo, Bot_Ultima_Sequencia, erro_multiplo
    );

endinterface

// File: rtl/condicionador_botoes_debouncer.sv
// rtl/condicionador_botoes_debouncer.sv - per-key polarity fix, 2-flop sync, debounce counter, rise detect
module debouncer_botao #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ATIVO_BAIXO     = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic nivel,
    output logic pulso_subida
);

    localparam int   CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic INVERTE = (ATIVO_BAIXO != 0);

    logic          pressionado;
    logic          sync_0;
    logic          sync_1;
    logic          nivel_ant;
    logic [CW-1:0] contador;

    // Internally 1 means pressed, so the sync flops reset to the released level 0.
    assign pressionado = raw ^ INVERTE;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_0    <= 1'b0;
            sync_1    <= 1'b0;
            nivel     <= 1'b0;
            nivel_ant <= 1'b0;
            contador  <= '0;
        end else begin
            sync_0    <= pressionado;
            sync_1    <= sync_0;
            nivel_ant <= nivel;
            if (sync_1 != nivel) begin
                if (contador == CW'(DEBOUNCE_CYCLES - 1)) begin
                    nivel    <= sync_1;
                    contador <= '0;
                end else begin
                    contador <= contador + CW'(1);
                end
            end else begin
                contador <= '0;
            end
        end
    end

    assign pulso_subida = nivel & ~nivel_ant;

endmodule

// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - key conditioner top; MULTI_PRESS_ERR_EN enables the erro_multiplo pulse
module condicionador_botoes
    import botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ATIVO_BAIXO     = 1
) (
    input logic                  clock,
    input logic                  reset,
    condicionador_botoes_if.slave bus
);

    logic [NUM_CORES-1:0] nivel_cor;
    logic [NUM_CORES-1:0] press_cor;
    logic                 press_ini;
    logic                 press_ult;
    logic [1:0]           nivel_ctrl_unused;

    estado_botoes_t       estado;
    logic [NUM_CORES-1:0] bot_pulso;
    logic [1:0]           cor_reg;
    logic                 ini_reg;
    logic                 ult_reg;
    logic                 erro_rej;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_cor
        debouncer_botao #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ATIVO_BAIXO    (ATIVO_BAIXO)
        ) u_deb (
            .clock       (clock),
            .reset       (reset),
            .raw         (bus.btn_cor_raw[i]),
            .nivel       (nivel_cor[i]),
            .pulso_subida(press_cor[i])
        );
    end

    debouncer_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ATIVO_BAIXO    (ATIVO_BAIXO)
    ) u_deb_iniciar (
        .clock       (clock),
        .reset       (reset),
        .raw         (bus.btn_iniciar_raw),
        .nivel       (nivel_ctrl_unused[0]),
        .pulso_subida(press_ini)
    );

    debouncer_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ATIVO_BAIXO    (ATIVO_BAIXO)
    ) u_deb_ultima (
        .clock       (clock),
        .reset       (reset),
        .raw         (bus.btn_ultima_raw),
        .nivel       (nivel_ctrl_unused[1]),
        .pulso_subida(press_ult)
    );

    // Control keys bypass the colour FSM; all pulses share the same output register stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            bot_pulso <= '0;
            cor_reg   <= 2'd0;
            ini_reg   <= 1'b0;
            ult_reg   <= 1'b0;
            erro_rej  <= 1'b0;
        end else begin
            bot_pulso <= '0;
            erro_rej  <= 1'b0;
            ini_reg   <= press_ini;
            ult_reg   <= press_ult;
            case (estado)
                OCIOSO: begin
                    if (press_cor != '0) begin
                        estado <= ESPERA_SOLTAR;
                        if (eh_one_hot(nivel_cor)) begin
                            bot_pulso <= nivel_cor;
                            cor_reg   <= codifica_cor(nivel_cor);
                        end else begin
                            erro_rej  <= 1'b1;
                        end
                    end
                end
                ESPERA_SOLTAR: begin
                    if (nivel_cor == '0) begin
                        estado <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign bus.Bot_Vermelho         = bot_pulso[VERMELHO];
    assign bus.Bot_Azul             = bot_pulso[AZUL];
    assign bus.Bot_Amarelo          = bot_pulso[AMARELO];
    assign bus.Bot_Verde            = bot_pulso[VERDE];
    assign bus.cor_codigo           = cor_reg;
    assign bus.Iniciar_Jogo         = ini_reg;
    assign bus.Bot_Ultima_Sequencia = ult_reg;

`ifdef MULTI_PRESS_ERR_EN
    assign bus.erro_multiplo = erro_rej;
`else
    logic erro_rej_unused;
    assign erro_rej_unused   = erro_rej;
    assign bus.erro_multiplo = 1'b0;
`endif

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - scoreboard bench for condicionador_botoes (DEBOUNCE_CYCLES=4, ATIVO_BAIXO=1)
module tb_condicionador_botoes;

    localparam int LAT = 7;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;
    logic [6:0] pulsos;

    always #5 clk = ~clk;

    condicionador_botoes_if ifc ();

    condicionador_botoes #(
        .DEBOUNCE_CYCLES(4),
        .ATIVO_BAIXO    (1)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus  (ifc)
    );

    // kind: 0 vermelho, 1 azul, 2 amarelo, 3 verde, 4 iniciar, 5 ultima, 6 erro
    assign pulsos = {ifc.erro_multiplo, ifc.Bot_Ultima_Sequencia, ifc.Iniciar_Jogo,
                     ifc.Bot_Verde, ifc.Bot_Amarelo, ifc.Bot_Azul, ifc.Bot_Vermelho};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 7; k++) begin
            if (pulsos[k] === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: got kind=%0d at cyc=%0d, required none", k, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.kind != k) begin
                        bad++;
                        $display("FAIL pulse_event: got kind=%0d cyc=%0d, required kind=%0d cyc=%0d",
                                 k, cyc, mon_e.kind, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int c, input int k);
        exp_q.push_back('{cyc: c, kind: k});
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset               = 1'b1;
        ifc.btn_cor_raw     = 4'b1111;
        ifc.btn_iniciar_raw = 1'b1;
        ifc.btn_ultima_raw  = 1'b1;
        tick(3);
        total++;
        if (pulsos !== 7'b0) begin
            bad++;
            $display("FAIL reset_pulses: got %b, required 0000000", pulsos);
        end
        total++;
        if (ifc.cor_codigo !== 2'd0) begin
            bad++;
            $display("FAIL reset_cor_codigo: got %0d, required 0", ifc.cor_codigo);
        end
        reset = 1'b0;
        tick(2);
        ifc.btn_cor_raw[2] = 1'b0;
        expect_ev(cyc + LAT, 2);
        tick(10);
        total++;
        if (ifc.cor_codigo !== 2'd2) begin
            bad++;
            $display("FAIL amarelo_cor_codigo: got %0d, required 2", ifc.cor_codigo);
        end
        ifc.btn_cor_raw[2] = 1'b1;
        tick(12);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_missing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        ifc.btn_cor_raw[1] = 1'b0; tick(2);
        ifc.btn_cor_raw[1] = 1'b1; tick(1);
        ifc.btn_cor_raw[1] = 1'b0; tick(2);
        ifc.btn_cor_raw[1] = 1'b1; tick(1);
        ifc.btn_cor_raw[1] = 1'b0;
        expect_ev(cyc + LAT, 1);
        tick(15);
        total++;
        if (ifc.cor_codigo !== 2'd1) begin
            bad++;
            $display("FAIL bounce_cor_codigo: got %0d, required 1", ifc.cor_codigo);
        end
        ifc.btn_cor_raw[1] = 1'b1;
        tick(12);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL bounce_missing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_held_key();
        ifc.btn_cor_raw[3] = 1'b0;
        expect_ev(cyc + LAT, 3);
        tick(200);
        ifc.btn_cor_raw[3] = 1'b1;
        tick(20);
        ifc.btn_cor_raw[3] = 1'b0;
        expect_ev(cyc + LAT, 3);
        tick(12);
        total++;
        if (ifc.cor_codigo !== 2'd3) begin
            bad++;
            $display("FAIL verde_cor_codigo: got %0d, required 3", ifc.cor_codigo);
        end
        ifc.btn_cor_raw[3] = 1'b1;
        tick(20);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL held_missing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_multi_press();
        ifc.btn_cor_raw = 4'b0110;
`ifdef MULTI_PRESS_ERR_EN
        expect_ev(cyc + LAT, 6);
`endif
        tick(15);
        total++;
        if (ifc.cor_codigo !== 2'd3) begin
            bad++;
            $display("FAIL multi_cor_codigo: got %0d, required 3", ifc.cor_codigo);
        end
        ifc.btn_cor_raw = 4'b1111;
        tick(15);
        ifc.btn_cor_raw[0] = 1'b0;
        expect_ev(cyc + LAT, 0);
        tick(12);
        total++;
        if (ifc.cor_codigo !== 2'd0) begin
            bad++;
            $display("FAIL vermelho_cor_codigo: got %0d, required 0", ifc.cor_codigo);
        end
        ifc.btn_cor_raw[0] = 1'b1;
        tick(15);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL multi_missing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_ignore_while_held();
        ifc.btn_cor_raw[0] = 1'b0;
        expect_ev(cyc + LAT, 0);
        tick(20);
        ifc.btn_cor_raw[1] = 1'b0;
        tick(20);
        ifc.btn_cor_raw[0] = 1'b1;
        tick(20);
        total++;
        if (ifc.cor_codigo !== 2'd0) begin
            bad++;
            $display("FAIL ignore_cor_codigo: got %0d, required 0", ifc.cor_codigo);
        end
        ifc.btn_cor_raw[1] = 1'b1;
        tick(15);
        ifc.btn_cor_raw[1] = 1'b0;
        expect_ev(cyc + LAT, 1);
        tick(12);
        ifc.btn_cor_raw[1] = 1'b1;
        tick(15);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL ignore_missing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        ifc.btn_cor_raw[2]  = 1'b0;
        ifc.btn_iniciar_raw = 1'b0;
        expect_ev(cyc + LAT, 2);
        expect_ev(cyc + LAT, 4);
        tick(15);
        ifc.btn_cor_raw[2]  = 1'b1;
        ifc.btn_iniciar_raw = 1'b1;
        tick(15);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_missing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_press();
        ifc.btn_ultima_raw = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        total++;
        if (ifc.cor_codigo !== 2'd0 || pulsos !== 7'b0) begin
            bad++;
            $display("FAIL midreset_state: got cor=%0d pulsos=%b, required cor=0 pulsos=0000000",
                     ifc.cor_codigo, pulsos);
        end
        reset = 1'b0;
        expect_ev(cyc + LAT, 5);
        tick(12);
        ifc.btn_ultima_raw = 1'b1;
        tick(12);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_missing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset               = 1'b1;
        ifc.btn_cor_raw     = 4'b1111;
        ifc.btn_iniciar_raw = 1'b1;
        ifc.btn_ultima_raw  = 1'b1;
        test_reset();
        test_bounce();
        test_held_key();
        test_multi_press();
        test_ignore_while_held();
        test_back_to_back();
        test_reset_mid_press();
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
Input stage directly upstream of the Chill_Out game FSM. It takes the raw pushbutton pins (four colour keys, start key and "last sequence" key) and makes them clean for the FSM:
- synchronises each pin to the clock;
- debounces each pin;
- converts each press into exactly one single-cycle pulse on the Bot_* / Iniciar_Jogo / Bot_Ultima_Sequencia inputs of Chill_Out;
- rejects simultaneous colour presses.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced level changes (5 ms at 100 MHz); legal range 1..2^20-1.
ATIVO_BAIXO, 1, 1 = raw pins read 0 when pressed; 0 = raw pins read 1 when pressed.

Ports:
clock  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
btn_cor_raw  in  4  raw colour keys; bit0 vermelho, bit1 azul, bit2 amarelo, bit3 verde.
btn_iniciar_raw  in  1  raw start key.
btn_ultima_raw  in  1  raw last-sequence key.
Bot_Vermelho  out  1  one-cycle pulse per accepted red press.
Bot_Azul  out  1  one-cycle pulse per accepted blue press.
Bot_Amarelo  out  1  one-cycle pulse per accepted yellow press.
Bot_Verde  out  1  one-cycle pulse per accepted green press.
cor_codigo  out  2  encoded colour of the last accepted press (0 vermelho, 1 azul, 2 amarelo, 3 verde); held until the next accepted press.
Iniciar_Jogo  out  1  one-cycle pulse per start press.
Bot_Ultima_Sequencia  out  1  one-cycle pulse per last-sequence press.
erro_multiplo  out  1  one-cycle pulse on a rejected multi-press; constant 0 unless MULTI_PRESS_ERR_EN is defined.

Behaviour:
- **Reset** (synchronous, active-high): all outputs are 0.
  - cor_codigo resets to 0.
  - Sync flops load the "released" level.
  - Debounced states are 0 (released) and counters are 0.
  - Colour FSM enters OCIOSO.
  - Reset asserted mid-press aborts any pending pulse. A key still held when reset releases is treated as a fresh press.
- **Polarity:** each pin is XORed with ATIVO_BAIXO, so that internally 1 = pressed.
- **Synchronisation:** each pin passes through a 2-flop synchroniser.
- **Debounce (per key):**
  - If the synced level differs from the debounced level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - Any cycle where the synced level equals the debounced level clears the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
- **Press event:** rising edge of a debounced level.
- **Latency:** a clean raw edge to its output pulse is exactly DEBOUNCE_CYCLES+3 rising clock edges (2 sync + DEBOUNCE_CYCLES + 1 register).
- **Control keys** (start and last-sequence):
  - Independent of each other and of the colour keys.
  - One pulse per debounced rising edge.
  - A release never produces a pulse.
- **Colour FSM states:**
  - OCIOSO:
    - If a colour press event occurs and the debounced colour vector is one-hot, pulse the matching Bot_* for 1 cycle, load cor_codigo, and go to ESPERA_SOLTAR.
    - If the debounced vector has 2 or more bits set, emit no Bot_* pulse, pulse erro_multiplo (when enabled), and go to ESPERA_SOLTAR.
  - ESPERA_SOLTAR:
    - All new colour presses are ignored.
    - When the debounced colour vector is all zero, go to OCIOSO (next press accepted from the following cycle).
- **Output guarantees:**
  - At most one Bot_* is high in any cycle.
  - No Bot_* is ever high for 2 consecutive cycles.
- **Simultaneous colour and control press:** both are accepted in the same cycle.
- **Held key:** exactly one pulse, with no auto-repeat.

Optional Feature:
MULTI_PRESS_ERR_EN
- Defined: erro_multiplo pulses for 1 cycle whenever OCIOSO rejects a multi-colour press. This lets Chill_Out or the LEDs flag a bad input.
- Undefined: erro_multiplo is tied to 0. Multi-presses are still rejected silently with identical FSM behaviour.

Decomposition:
- Package botoes_pkg:
  - typedef enum cor_t {VERMELHO=0, AZUL=1, AMARELO=2, VERDE=3};
  - typedef enum estado_botoes_t {OCIOSO, ESPERA_SOLTAR};
  - constant NUM_CORES=4.
- Sub-module debouncer_botao:
  - Parameters: DEBOUNCE_CYCLES, ATIVO_BAIXO.
  - Ports: clock, reset, raw, nivel, pulso_subida.
  - Contains the polarity inversion, synchroniser, counter and edge detector.
  - Instantiated 6 times.
- The top level holds only the colour FSM, encoder and output registers.

Test Plan:
(bench uses DEBOUNCE_CYCLES=4, ATIVO_BAIXO=1)
1. Reset held 3 cycles with btn_cor_raw=4'b1111 -> all outputs 0, cor_codigo=0. Hold bit2 low from cycle 10 -> Bot_Amarelo high only in cycle 17, cor_codigo=2.
2. Bounce on the azul pin: low 2 cycles, high 1, low 2, then steady low -> exactly one Bot_Azul pulse, 7 cycles after the steady-low start.
3. Verde held 200 cycles, then released, then pressed again -> exactly 2 Bot_Verde pulses, no pulse on release.
4. Vermelho and verde pressed in the same cycle -> no Bot_* pulse; erro_multiplo pulses once with the macro, stays 0 without. Release both, then press vermelho -> Bot_Vermelho pulse.
5. Vermelho held, then azul pressed while vermelho is still held -> only the Bot_Vermelho pulse; azul is ignored until all colours are released.
6. Start and amarelo pressed together -> Iniciar_Jogo and Bot_Amarelo pulse in the same cycle. Reset asserted 2 cycles into the debounce window -> no pulse before reset.
